arb_rr4: RTL and testbench

ARB_RR4 -- requirements
Module: arb_rr4

---
 rtl/arb_pkg.sv | 25 ++
 rtl/arb_rr4_if.sv | 26 ++
 rtl/decoder_2to4.sv | 10 +
 rtl/arb_rr4.sv | 88 ++++++++
 tb/tb_arb_rr4.sv | 124 ++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds the FSM state encoding, the requester count and the winner-search helper.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // First set request at or above ptr, wrapping 3->0; returns ptr when req is empty.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/arb_rr4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
interface arb_rr4_if import arb_pkg::*; ();

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );

endinterface

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with an enable; output is all-zero when disabled.
module decoder_2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    assign y = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter with hold-until-release grants, a one-cycle
// gap between grants and an optional MAX_HOLD limit that forces a release.
module arb_rr4 import arb_pkg::*; #(
    parameter int MAX_HOLD = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    arb_rr4_if.slave  bus
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    // The counter parks at all-ones so an unlimited hold never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_t           state, state_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;
    logic [IDX_W-1:0] grant_idx, grant_idx_nx;
    logic [CNT_W-1:0] hold_cnt, hold_nx;
    logic             timeout, timeout_nx;
    logic             grant_valid;
    logic             released;
    logic             expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            hold_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            grant_idx <= grant_idx_nx;
            hold_cnt  <= hold_nx;
            timeout   <= timeout_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        grant_idx_nx = grant_idx;
        hold_nx      = hold_cnt;
        timeout_nx   = 1'b0;
        released     = !bus.req[grant_idx];
        expired      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

        unique case (state)
            IDLE, GAP: begin
                if (|bus.req) begin
                    state_nx     = GRANT;
                    grant_idx_nx = rr_pick(bus.req, ptr);
                    hold_nx      = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            GRANT: begin
                // A release on the limit edge wins, so timeout fires only on a forced revoke.
                if (released || expired) begin
                    state_nx   = GAP;
                    ptr_nx     = grant_idx + IDX_W'(1);
                    timeout_nx = !released;
                end else begin
                    hold_nx = sat_inc(hold_cnt);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign grant_valid     = (state == GRANT);
    assign bus.grant_valid = grant_valid;
    assign bus.grant_idx   = grant_idx;
    assign bus.timeout     = timeout;

    decoder_2to4 u_dec (
        .sel (grant_idx),
        .en  (grant_valid),
        .y   (bus.grant)
    );

endmodule

// File: tb/tb_arb_rr4.sv
// Directed bench for arb_rr4: one instance without a hold limit, one with MAX_HOLD=16.
module tb_arb_rr4;
    import arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    arb_rr4_if if0 ();
    arb_rr4_if if16 ();

    arb_rr4 #(.MAX_HOLD(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    arb_rr4 #(.MAX_HOLD(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp16(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic to);
        chk({tag, ".grant"},   32'(if16.grant),       32'(g));
        chk({tag, ".idx"},     32'(if16.grant_idx),   32'(idx));
        chk({tag, ".valid"},   32'(if16.grant_valid), 32'(g != 4'b0000));
        chk({tag, ".timeout"}, 32'(if16.timeout),     32'(to));
    endtask

    initial begin
        rst_n    = 1'b0;
        if0.req  = 4'b0000;
        if16.req = 4'b0000;
        #2;
        exp16("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset0.grant", 32'(if0.grant), 32'h0);
        chk("reset0.timeout", 32'(if0.timeout), 32'h0);
        #10 rst_n = 1'b1;

        // Unlimited hold: requester 0 keeps the grant indefinitely.
        if0.req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("nolimit.grant[%0d]", i), 32'(if0.grant), 32'h1);
            chk($sformatf("nolimit.timeout[%0d]", i), 32'(if0.timeout), 32'h0);
        end
        if0.req = 4'b0000;
        step();
        chk("nolimit.gap", 32'(if0.grant), 32'h0);
        exp16("idle16", 4'b0000, 2'd0, 1'b0);

        // Requester 0 drops after three grant cycles, requester 2 follows after the gap.
        if16.req = 4'b0101;
        step(); exp16("r0.c1", 4'b0001, 2'd0, 1'b0);
        step(); exp16("r0.c2", 4'b0001, 2'd0, 1'b0);
        step(); exp16("r0.c3", 4'b0001, 2'd0, 1'b0);
        if16.req = 4'b0100;
        step(); exp16("r0.gap", 4'b0000, 2'd0, 1'b0);
        step(); exp16("r2.grant", 4'b0100, 2'd2, 1'b0);

        // ptr=3 after requester 2, so 0011 wraps to index 0, then index 1.
        if16.req = 4'b0011;
        step(); exp16("wrap.gap", 4'b0000, 2'd2, 1'b0);
        step(); exp16("wrap.idx0", 4'b0001, 2'd0, 1'b0);
        if16.req = 4'b0000;
        step(); exp16("wrap.gap2", 4'b0000, 2'd0, 1'b0);
        if16.req = 4'b0011;
        step(); exp16("wrap.idx1", 4'b0010, 2'd1, 1'b0);

        // Requester 3 holds past the limit; other requests toggle without effect.
        if16.req = 4'b1000;
        step(); exp16("lim.gap", 4'b0000, 2'd1, 1'b0);
        step(); exp16("lim.c1", 4'b1000, 2'd3, 1'b0);
        for (int k = 2; k <= 16; k++) begin
            if16.req = (k < 16 && (k % 2) == 1) ? 4'b1111 : 4'b1000;
            step(); exp16($sformatf("lim.c%0d", k), 4'b1000, 2'd3, 1'b0);
        end
        if16.req = 4'b1000;
        step(); exp16("lim.timeout", 4'b0000, 2'd3, 1'b1);
        step(); exp16("lim.regrant", 4'b1000, 2'd3, 1'b0);

        // Release on the same edge as the limit: treated as a release.
        for (int k = 2; k <= 16; k++) begin
            step(); exp16($sformatf("rel.c%0d", k), 4'b1000, 2'd3, 1'b0);
        end
        if16.req = 4'b0000;
        step(); exp16("rel.gap", 4'b0000, 2'd3, 1'b0);

        // Asynchronous reset in the middle of a grant to requester 1.
        if16.req = 4'b0001;
        step(); exp16("rst.g0", 4'b0001, 2'd0, 1'b0);
        if16.req = 4'b0010;
        step(); exp16("rst.gap", 4'b0000, 2'd0, 1'b0);
        step(); exp16("rst.g1", 4'b0010, 2'd1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        exp16("rst.async", 4'b0000, 2'd0, 1'b0);
        chk("rst.async0", 32'(if0.grant), 32'h0);
        if16.req = 4'b0110;
        #2 rst_n = 1'b1;
        step(); exp16("rst.after", 4'b0010, 2'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
